// File: rtl/nn_reg_pkg.sv
// Shared register map, sequence length and FSM state type for the NN register-map master.
package nn_reg_pkg;

    localparam int unsigned REG_COUNT = 11;

    localparam logic [31:0] OFF_OPA    = 32'h00;
    localparam logic [31:0] OFF_OPB    = 32'h04;
    localparam logic [31:0] OFF_W11    = 32'h08;
    localparam logic [31:0] OFF_W12    = 32'h0C;
    localparam logic [31:0] OFF_W21    = 32'h10;
    localparam logic [31:0] OFF_W22    = 32'h14;
    localparam logic [31:0] OFF_B1     = 32'h18;
    localparam logic [31:0] OFF_B2     = 32'h1C;
    localparam logic [31:0] OFF_W31    = 32'h20;
    localparam logic [31:0] OFF_W32    = 32'h24;
    localparam logic [31:0] OFF_B3     = 32'h28;
    localparam logic [31:0] OFF_RESULT = 32'h30;

    // Write slot i of a sequence goes to REG_OFFSET[i]; slots 0-1 are the operands.
    localparam logic [31:0] REG_OFFSET [REG_COUNT] = '{
        OFF_OPA, OFF_OPB, OFF_W11, OFF_W12, OFF_W21, OFF_W22,
        OFF_B1, OFF_B2, OFF_W31, OFF_W32, OFF_B3
    };

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWaitNn,
        StRead,
        StDone,
        StErr
    } state_t;

endpackage

// File: rtl/nn_timeout_ctr.sv
// Wait-window cycle counter: cleared by load_i, advances while en_i, flags the final allowed cycle.
module nn_timeout_ctr #(
    parameter int unsigned Width = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [Width-1:0] last_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == last_i);

endmodule

// File: rtl/nn_reg_master.sv
// Bus master that programs the NN register map, waits for nn_done, then reads back the result.
module nn_reg_master
    import nn_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned NN_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load_weights,
    input  logic [31:0] opA_in,
    input  logic [31:0] opB_in,
    input  logic [31:0] w11_in,
    input  logic [31:0] w12_in,
    input  logic [31:0] w21_in,
    input  logic [31:0] w22_in,
    input  logic [31:0] b1_in,
    input  logic [31:0] b2_in,
    input  logic [31:0] w31_in,
    input  logic [31:0] w32_in,
    input  logic [31:0] b3_in,
    input  logic        nn_done,
    input  logic        ack,
    input  logic [31:0] rddata,
    output logic [31:0] addr,
    output logic        wren,
    output logic [31:0] wrdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result_out
);

    localparam int unsigned MaxTimeout = (ACK_TIMEOUT > NN_TIMEOUT) ? ACK_TIMEOUT : NN_TIMEOUT;
    localparam int unsigned CtrW       = $clog2(MaxTimeout + 1);
    localparam logic [CtrW-1:0] AckLast = CtrW'(ACK_TIMEOUT - 1);
    localparam logic [CtrW-1:0] NnLast  = CtrW'(NN_TIMEOUT - 1);

    state_t          state_q;
    logic [3:0]      idx_q;
    logic            lw_q;
    logic [31:0]     vals_q [REG_COUNT];
    logic [3:0]      last_idx;
    logic            waiting;
    logic            hit;
    logic            expired;
    logic            ctr_load;
    logic            timeout;
    logic [CtrW-1:0] ctr_last;

    assign last_idx = lw_q ? 4'(REG_COUNT - 1) : 4'd1;

    // The counter runs only while an access or nn_done is outstanding; the gap cycle between
    // writes and every completing event clear it, so each wait window starts from zero.
    always_comb begin
        waiting  = 1'b0;
        hit      = 1'b0;
        ctr_last = AckLast;
        unique case (state_q)
            StWrite: begin
                waiting = wren;
                hit     = wren && ack;
            end
            StWaitNn: begin
                waiting  = 1'b1;
                hit      = nn_done;
                ctr_last = NnLast;
            end
            StRead: begin
                waiting = 1'b1;
                hit     = ack;
            end
            default: ;
        endcase
    end

    assign ctr_load = !waiting || hit;
    assign timeout  = expired && !hit;

    nn_timeout_ctr #(
        .Width(CtrW)
    ) u_timeout (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (ctr_load),
        .en_i     (waiting),
        .last_i   (ctr_last),
        .expired_o(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            lw_q       <= 1'b0;
            addr       <= '0;
            wren       <= 1'b0;
            wrdata     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            result_out <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                vals_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (timeout) begin
                state_q <= StErr;
                wren    <= 1'b0;
                busy    <= 1'b0;
                err     <= 1'b1;
                done    <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            vals_q[0]  <= opA_in;
                            vals_q[1]  <= opB_in;
                            vals_q[2]  <= w11_in;
                            vals_q[3]  <= w12_in;
                            vals_q[4]  <= w21_in;
                            vals_q[5]  <= w22_in;
                            vals_q[6]  <= b1_in;
                            vals_q[7]  <= b2_in;
                            vals_q[8]  <= w31_in;
                            vals_q[9]  <= w32_in;
                            vals_q[10] <= b3_in;
                            lw_q       <= load_weights;
                            idx_q      <= '0;
                            addr       <= BASE_ADDR + OFF_OPA;
                            wrdata     <= opA_in;
                            wren       <= 1'b1;
                            busy       <= 1'b1;
                            err        <= 1'b0;
                            state_q    <= StWrite;
                        end
                    end
                    StWrite: begin
                        if (!wren) begin
                            addr   <= BASE_ADDR + REG_OFFSET[idx_q];
                            wrdata <= vals_q[idx_q];
                            wren   <= 1'b1;
                        end else if (ack) begin
                            wren <= 1'b0;
                            if (idx_q == last_idx) begin
                                state_q <= StWaitNn;
                            end else begin
                                idx_q <= idx_q + 4'd1;
                            end
                        end
                    end
                    StWaitNn: begin
                        if (nn_done) begin
                            addr    <= BASE_ADDR + OFF_RESULT;
                            state_q <= StRead;
                        end
                    end
                    StRead: begin
                        if (ack) begin
                            result_out <= rddata;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state_q    <= StDone;
                        end
                    end
                    StDone, StErr: state_q <= StIdle;
                    default:       state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nn_reg_master.sv
// Self-checking bench for nn_reg_master: scripted bus slave plus a register-map reference model.
module tb_nn_reg_master;

    localparam logic [31:0] Base  = 32'h3000_0000;
    localparam int          AckTo = 16;
    localparam int          NnTo  = 1024;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, load_weights = 1'b0;
    logic        nn_done = 1'b0, ack = 1'b0;
    logic [31:0] opA_in = '0, opB_in = '0, w11_in = '0, w12_in = '0, w21_in = '0, w22_in = '0;
    logic [31:0] b1_in = '0, b2_in = '0, w31_in = '0, w32_in = '0, b3_in = '0, rddata = '0;
    logic [31:0] addr, wrdata, result_out;
    logic        wren, busy, done, err;

    always #5 clk = ~clk;

    nn_reg_master #(
        .BASE_ADDR(Base), .ACK_TIMEOUT(AckTo), .NN_TIMEOUT(NnTo)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .load_weights(load_weights),
        .opA_in(opA_in), .opB_in(opB_in), .w11_in(w11_in), .w12_in(w12_in),
        .w21_in(w21_in), .w22_in(w22_in), .b1_in(b1_in), .b2_in(b2_in),
        .w31_in(w31_in), .w32_in(w32_in), .b3_in(b3_in),
        .nn_done(nn_done), .ack(ack), .rddata(rddata),
        .addr(addr), .wren(wren), .wrdata(wrdata), .busy(busy), .done(done), .err(err),
        .result_out(result_out)
    );

    int          n_cmp = 0, n_fail = 0;
    logic [31:0] in_v [11];
    logic [31:0] exp_vals [11];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    int          gap_bad, stab_bad, done_cnt, wait_cycles, last_len, read_cnt;
    logic [31:0] read_addr, result_after;
    logic        err_first, busy_first, wren_first, err_at_done, busy_at_done, wren_at_done;
    logic        err_after, busy_after;
    bit          hung;

    // Register map model: operands always, weights/biases only when load_weights was set.
    function automatic int exp_count(input bit lw);
        return lw ? 11 : 2;
    endfunction

    task automatic apply_inputs();
        opA_in = in_v[0]; opB_in = in_v[1]; w11_in = in_v[2]; w12_in = in_v[3];
        w21_in = in_v[4]; w22_in = in_v[5]; b1_in = in_v[6]; b2_in = in_v[7];
        w31_in = in_v[8]; w32_in = in_v[9]; b3_in = in_v[10];
    endtask

    // Starts one sequence and plays the slave until the done pulse ends (or the budget runs out).
    // nack_idx: write slot never acked; nn_lat 0: nn_done never sent; race: slot 1 acked on the
    // last allowed cycle and start toggled while busy; stop5: return at the 5th write.
    task automatic run_seq(input bit lw, input logic [31:0] opa, input logic [31:0] opb,
                           input int lat, input int nack_idx, input int nn_lat, input bit race,
                           input bit stop5, input logic [31:0] rd);
        int          nexp = exp_count(lw);
        int          req_len = 0;
        bit          prev_acc = 0, nn_fired = 0, in_req;
        logic [31:0] req_addr = '0, req_data = '0;
        log_addr.delete(); log_data.delete();
        gap_bad = 0; stab_bad = 0; done_cnt = 0; wait_cycles = 0; last_len = 0; read_cnt = 0;
        read_addr = '0; hung = 1;
        @(negedge clk);
        for (int i = 0; i < 11; i++) in_v[i] = $urandom;
        in_v[0] = opa; in_v[1] = opb;
        for (int i = 0; i < 11; i++) exp_vals[i] = in_v[i];
        apply_inputs();
        load_weights = lw;
        start = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = (race && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int i = 0; i < 11; i++) in_v[i] = $urandom;
            apply_inputs();
            load_weights = 1'($urandom_range(0, 1));
            if (cyc == 0) begin
                err_first = err; busy_first = busy; wren_first = wren;
            end
            if (stop5 && wren && addr == Base + 32'h10) begin
                hung = 0; ack = 1'b0; start = 1'b0; nn_done = 1'b0;
                return;
            end
            in_req = wren || (busy && addr == Base + 32'h30);
            if (prev_acc && wren) gap_bad++;
            prev_acc = 0;
            if (in_req) begin
                req_len++;
                if (req_len == 1) begin
                    req_addr = addr; req_data = wrdata;
                end else if (addr !== req_addr || (wren && wrdata !== req_data)) begin
                    stab_bad++;
                end
                last_len = req_len;
            end else begin
                req_len = 0;
            end
            if (busy && !in_req && log_addr.size() == nexp) wait_cycles++;
            if (!in_req) ack = 1'b0;
            else if (wren && log_addr.size() == nack_idx) ack = 1'b0;
            else if (race && wren && log_addr.size() == 1) ack = (req_len == AckTo);
            else ack = (req_len > lat);
            rddata = (ack && !wren) ? rd : $urandom;
            if (ack && wren) begin
                log_addr.push_back(addr); log_data.push_back(wrdata); prev_acc = 1;
            end
            if (ack && !wren) begin
                read_cnt++; read_addr = addr;
            end
            // A stray nn_done during the first write must not shortcut the sequence.
            if (log_addr.size() == 0 && req_len == 1) nn_done = 1'b1;
            else if (!nn_fired && nn_lat > 0 && wait_cycles == nn_lat) begin
                nn_done = 1'b1; nn_fired = 1;
            end else nn_done = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    err_at_done = err; busy_at_done = busy; wren_at_done = wren;
                end
            end else if (done_cnt > 0) begin
                err_after = err; busy_after = busy; result_after = result_out; hung = 0;
                break;
            end
        end
        start = 1'b0; ack = 1'b0; nn_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: wren/busy/done/err=%b%b%b%b want 0000", wren, busy, done, err);
        end
        n_cmp++; if (addr !== 32'h0 || wrdata !== 32'h0 || result_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: addr=%h wrdata=%h result=%h want 0", addr, wrdata, result_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_load();
        logic [31:0] rd = $urandom;
        int nexp = exp_count(1'b1);
        run_seq(1'b1, 32'h1234_5678, 32'h8765_4321, 1, -1, $urandom_range(1, 8), 1'b0, 1'b0, rd);
        n_cmp++; if (log_addr.size() != nexp) begin
            n_fail++; $display("FAIL full_load_count: got %0d writes want %0d", log_addr.size(), nexp);
        end
        for (int i = 0; i < nexp && i < log_addr.size(); i++) begin
            n_cmp++; if (log_addr[i] !== Base + 32'(4 * i) || log_data[i] !== exp_vals[i]) begin
                n_fail++; $display("FAIL full_load_write%0d: got %h<=%h want %h<=%h", i, log_addr[i],
                                   log_data[i], Base + 32'(4 * i), exp_vals[i]);
            end
        end
        n_cmp++; if (gap_bad != 0 || stab_bad != 0) begin
            n_fail++; $display("FAIL full_load_bus: gap_viol=%0d unstable=%0d want 0/0", gap_bad, stab_bad);
        end
        n_cmp++; if (done_cnt != 1 || err_after !== 1'b0 || result_after !== rd) begin
            n_fail++; $display("FAIL full_load_end: done_len=%0d err=%b result=%h want 1/0/%h",
                               done_cnt, err_after, result_after, rd);
        end
    endtask

    task automatic test_ops_only();
        int nexp = exp_count(1'b0);
        run_seq(1'b0, $urandom, $urandom, $urandom_range(0, 3), -1, 5, 1'b0, 1'b0, 32'hDEAD_BEEF);
        n_cmp++; if (busy_first !== 1'b1 || wren_first !== 1'b1) begin
            n_fail++; $display("FAIL ops_first_cycle: busy=%b wren=%b want 1/1", busy_first, wren_first);
        end
        n_cmp++; if (log_addr.size() != nexp) begin
            n_fail++; $display("FAIL ops_count: got %0d writes want %0d", log_addr.size(), nexp);
        end
        for (int i = 0; i < nexp && i < log_addr.size(); i++) begin
            n_cmp++; if (log_addr[i] !== Base + 32'(4 * i) || log_data[i] !== exp_vals[i]) begin
                n_fail++; $display("FAIL ops_write%0d: got %h<=%h want %h<=%h", i, log_addr[i],
                                   log_data[i], Base + 32'(4 * i), exp_vals[i]);
            end
        end
        n_cmp++; if (wait_cycles != 5) begin
            n_fail++; $display("FAIL ops_wait_nn: got %0d cycles want 5", wait_cycles);
        end
        n_cmp++; if (read_cnt != 1 || read_addr !== Base + 32'h30) begin
            n_fail++; $display("FAIL ops_read: reads=%0d addr=%h want 1/%h", read_cnt, read_addr, Base + 32'h30);
        end
        n_cmp++; if (result_after !== 32'hDEAD_BEEF || done_cnt != 1 || busy_after !== 1'b0) begin
            n_fail++; $display("FAIL ops_end: result=%h done_len=%0d busy=%b want deadbeef/1/0",
                               result_after, done_cnt, busy_after);
        end
    endtask

    task automatic test_ack_timeout();
        run_seq(1'($urandom_range(0, 1)), $urandom, $urandom, 1, 1, 4, 1'b0, 1'b0, $urandom);
        n_cmp++; if (log_addr.size() != 1 || last_len != AckTo) begin
            n_fail++; $display("FAIL ack_to_len: writes=%0d wren_cycles=%0d want 1/%0d",
                               log_addr.size(), last_len, AckTo);
        end
        n_cmp++; if (err_at_done !== 1'b1 || wren_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
            n_fail++; $display("FAIL ack_to_err: err=%b wren=%b busy=%b want 1/0/0",
                               err_at_done, wren_at_done, busy_at_done);
        end
        n_cmp++; if (done_cnt != 1 || err_after !== 1'b1) begin
            n_fail++; $display("FAIL ack_to_end: done_len=%0d err_after=%b want 1/1", done_cnt, err_after);
        end
    endtask

    task automatic test_nn_timeout();
        logic [31:0] rd = $urandom;
        run_seq(1'b0, $urandom, $urandom, $urandom_range(0, 2), -1, 0, 1'b0, 1'b0, $urandom);
        n_cmp++; if (wait_cycles != NnTo || read_cnt != 0) begin
            n_fail++; $display("FAIL nn_to_wait: got %0d cycles reads=%0d want %0d/0", wait_cycles, read_cnt, NnTo);
        end
        n_cmp++; if (err_at_done !== 1'b1 || done_cnt != 1 || busy_at_done !== 1'b0) begin
            n_fail++; $display("FAIL nn_to_err: err=%b done_len=%0d busy=%b want 1/1/0",
                               err_at_done, done_cnt, busy_at_done);
        end
        run_seq(1'b0, $urandom, $urandom, 1, -1, 3, 1'b0, 1'b0, rd);
        n_cmp++; if (err_first !== 1'b0) begin
            n_fail++; $display("FAIL nn_to_clear: err=%b after start want 0", err_first);
        end
        n_cmp++; if (err_after !== 1'b0 || result_after !== rd || done_cnt != 1) begin
            n_fail++; $display("FAIL nn_to_recover: err=%b result=%h done_len=%0d want 0/%h/1",
                               err_after, result_after, done_cnt, rd);
        end
    endtask

    task automatic test_busy_start_race();
        logic [31:0] rd = $urandom;
        int nexp = exp_count(1'b1);
        int bad = 0;
        run_seq(1'b1, $urandom, $urandom, $urandom_range(0, 3), -1, $urandom_range(1, 6),
                1'b1, 1'b0, rd);
        n_cmp++; if (log_addr.size() != nexp) begin
            n_fail++; $display("FAIL race_count: got %0d writes want %0d", log_addr.size(), nexp);
        end
        for (int i = 0; i < nexp && i < log_addr.size(); i++) begin
            if (log_addr[i] !== Base + 32'(4 * i) || log_data[i] !== exp_vals[i]) bad++;
        end
        n_cmp++; if (bad != 0) begin
            n_fail++; $display("FAIL race_data: got %0d wrong writes want 0", bad);
        end
        n_cmp++; if (err_after !== 1'b0 || done_cnt != 1 || result_after !== rd) begin
            n_fail++; $display("FAIL race_end: err=%b done_len=%0d result=%h want 0/1/%h",
                               err_after, done_cnt, result_after, rd);
        end
    endtask

    task automatic test_reset_mid();
        run_seq(1'b1, $urandom, $urandom, 1, -1, 5, 1'b0, 1'b1, $urandom);
        n_cmp++; if (hung || log_addr.size() != 4) begin
            n_fail++; $display("FAIL rst_mid_reach: reached=%b writes=%0d want 1/4", !hung, log_addr.size());
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (wren !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_wren: got %b want 0", wren);
        end
        n_cmp++; if ({addr, wrdata, result_out} !== 96'd0 || {busy, done, err} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_outs: addr=%h wrdata=%h result=%h busy/done/err=%b%b%b want 0",
                               addr, wrdata, result_out, busy, done, err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_cmp++; if (busy !== 1'b0 || wren !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_idle: busy=%b wren=%b want 0/0", busy, wren);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] rd = $urandom;
            bit lw = 1'($urandom_range(0, 1));
            int nexp = exp_count(lw);
            int bad = 0;
            run_seq(lw, $urandom, $urandom, $urandom_range(0, 3), -1, $urandom_range(1, 10),
                    1'b0, 1'b0, rd);
            for (int i = 0; i < nexp && i < log_addr.size(); i++) begin
                if (log_addr[i] !== Base + 32'(4 * i) || log_data[i] !== exp_vals[i]) bad++;
            end
            n_cmp++; if (log_addr.size() != nexp || bad != 0 || gap_bad != 0 || stab_bad != 0) begin
                n_fail++; $display("FAIL b2b%0d_writes: count=%0d bad=%0d gaps=%0d unstable=%0d want %0d/0/0/0",
                                   k, log_addr.size(), bad, gap_bad, stab_bad, nexp);
            end
            n_cmp++; if (result_after !== rd || done_cnt != 1 || err_after !== 1'b0) begin
                n_fail++; $display("FAIL b2b%0d_end: result=%h done_len=%0d err=%b want %h/1/0",
                                   k, result_after, done_cnt, err_after, rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_ops_only();
        test_ack_timeout();
        test_nn_timeout();
        test_busy_start_race();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
